// File: rtl/instr_issue_unit_if.sv
// ---------------------------------------------------------------------------
// instr_issue_unit_if
// Upstream instruction handshake between an instruction source and the
// instr_issue_unit.
//   in_valid  : source offers an instruction on in_instr
//   in_instr  : 16-bit instruction word
//   in_ready  : issue unit can accept an instruction this cycle
// Modports: master = instruction source, slave = issue unit.
// ---------------------------------------------------------------------------
interface instr_issue_unit_if;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;

    modport master (output in_valid, output in_instr, input in_ready);
    modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/instr_issue_unit.sv
// ---------------------------------------------------------------------------
// instr_issue_unit
// Latches one instruction at a time into a 16-bit IR, decodes its fields,
// hands it to a datapath controller with a one-cycle start pulse and waits
// for the controller's w flag to go busy and then idle again before taking
// the next instruction.
//
// Ports
//   clk              sole clock, rising edge
//   reset            asynchronous, active-low
//   up (slave)       in_valid / in_instr / in_ready upstream handshake
//   w                controller waiting flag (1 = idle/finished)
//   nsel             one-hot register select: 001 Rn, 010 Rd, 100 Rm
//   s                start pulse to controller (registered)
//   opcode/op/shift  IR[15:13] / IR[12:11] / IR[4:3]
//   sximm5/sximm8    IR[4:0] / IR[7:0] sign-extended to 16 bits
//   readnum/writenum register number picked by nsel (000 for other nsel)
//   done             one-cycle pulse when an issued instruction completes
//   err              one-cycle pulse on a rejected instruction
//   retired          wrapping count of completed instructions
//
// Build option: define ILLEGAL_OP_TRAP_EN to reject accepted instructions
// whose {opcode,op} is not a supported MOV/ALU encoding; err pulses and the
// instruction is never issued. Without it err is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a new instruction (in_ready = 1)
// ISSUE     | s asserted for this single cycle
// WAIT_BUSY | waiting for the controller to drop w (it has seen s)
// WAIT_DONE | waiting for w to rise again; done pulses on that edge
// ---------------------------------------------------------------------------
module instr_issue_unit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    instr_issue_unit_if.slave up,
    input  logic             w,
    input  logic [2:0]       nsel,
    output logic             s,
    output logic [2:0]       opcode,
    output logic [1:0]       op,
    output logic [1:0]       shift,
    output logic [15:0]      sximm5,
    output logic [15:0]      sximm8,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;
    logic        accept;
    logic        illegal;
    logic        s_nxt;
    logic        done_nxt;
    logic        err_nxt;

    assign up.in_ready = (state == IDLE);
    assign accept      = up.in_valid & up.in_ready;

    // Legality is judged on the incoming word so the trap decision is made
    // on the same edge that loads the IR.
`ifdef ILLEGAL_OP_TRAP_EN
    always_comb begin
        case (up.in_instr[15:11])
            5'b11010, 5'b11000,
            5'b10100, 5'b10101,
            5'b10110, 5'b10111: illegal = 1'b0;
            default:            illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

    // State register plus registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ir      <= '0;
            retired <= '0;
            s       <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            if (accept) begin
                ir <= up.in_instr;
            end
            if (done_nxt) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !illegal) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!w) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (w) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic: values the registered pulses take on the next edge
    always_comb begin
        s_nxt    = (state_nxt == ISSUE);
        done_nxt = (state == WAIT_DONE) && w;
        err_nxt  = accept && illegal;
    end

    // Field decode straight from the IR
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign shift  = ir[4:3];
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    always_comb begin
        case (nsel)
            3'b001:  readnum = ir[10:8];
            3'b010:  readnum = ir[7:5];
            3'b100:  readnum = ir[2:0];
            default: readnum = 3'b000;
        endcase
    end

    assign writenum = readnum;

endmodule

// File: tb/tb_instr_issue_unit.sv
module tb_instr_issue_unit;

    localparam int CNT_W = 8;
`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             w = 1'b1;
    logic [2:0]       nsel = 3'b001;
    logic             s;
    logic [2:0]       opcode;
    logic [1:0]       op;
    logic [1:0]       shift;
    logic [15:0]      sximm5;
    logic [15:0]      sximm8;
    logic [2:0]       readnum;
    logic [2:0]       writenum;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] retired;

    instr_issue_unit_if bus ();

    instr_issue_unit #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .up       (bus),
        .w        (w),
        .nsel     (nsel),
        .s        (s),
        .opcode   (opcode),
        .op       (op),
        .shift    (shift),
        .sximm5   (sximm5),
        .sximm8   (sximm8),
        .readnum  (readnum),
        .writenum (writenum),
        .done     (done),
        .err      (err),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] ins;
        bit          illegal;
        int          acc;
        bit          issued;
    } item_t;

    item_t       sb_q[$];
    item_t       it;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          model_ret = 0;
    logic [15:0] m_ir = 16'h0000;
    bit          exp_ready;

    bit ctl_rand = 1'b0;
    int ctl_drop = 0;
    int ctl_busy = 3;
    int ctl_rise_cyc = -100;
    bit nsel_auto = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event expected none (t=%0t)", name, $time);
    endtask

    // ---- reference model (spec-level arithmetic) ----
    function automatic bit legal(input logic [15:0] ins);
        int k;
        k = int'(ins) / 2048;
        return (k == 26) || (k == 24) || (k >= 20 && k <= 23);
    endfunction

    function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
        int x;
        x = int'(v) % (1 << bits);
        if (x >= (1 << (bits - 1))) x = x - (1 << bits);
        return 16'(x);
    endfunction

    function automatic logic [2:0] exp_reg(input logic [15:0] ir, input logic [2:0] sel);
        int v;
        v = int'(ir);
        if (sel == 3'b001) return 3'((v / 256) % 8);
        if (sel == 3'b010) return 3'((v / 32) % 8);
        if (sel == 3'b100) return 3'(v % 8);
        return 3'd0;
    endfunction

    function automatic logic [15:0] rand_instr(input bit want_legal);
        int k;
        int codes[6] = '{26, 24, 20, 21, 22, 23};
        if (want_legal) k = codes[$urandom_range(0, 5)];
        else begin
            k = $urandom_range(0, 31);
            while (k == 26 || k == 24 || (k >= 20 && k <= 23)) k = $urandom_range(0, 31);
        end
        return 16'(k * 2048 + $urandom_range(0, 2047));
    endfunction

    // ---- controller model: drops w some cycles after s, raises it later ----
    initial begin
        int dly;
        int busy;
        forever begin
            @(negedge clk);
            if (s && reset) begin
                dly  = ctl_rand ? $urandom_range(0, 2) : ctl_drop;
                busy = ctl_rand ? $urandom_range(1, 4) : ctl_busy;
                @(posedge clk);
                repeat (dly) @(posedge clk);
                #1 w = 1'b0;
                repeat (busy) @(posedge clk);
                #1 w = 1'b1;
                ctl_rise_cyc = cyc;
            end
        end
    end

    initial begin
        int r;
        forever begin
            @(posedge clk);
            #1;
            if (nsel_auto) begin
                r = $urandom_range(0, 4);
                if (r == 0) nsel = 3'b001;
                else if (r == 1) nsel = 3'b010;
                else if (r == 2) nsel = 3'b100;
                else nsel = 3'($urandom_range(0, 7));
            end
        end
    end

    // ---- monitor / scoreboard ----
    always @(negedge clk) begin
        if (reset) begin
            exp_ready = (sb_q.size() == 0) || done || err;
            chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            if (s) begin
                if (sb_q.size() == 0) fail("s_unexpected");
                else begin
                    chk("s_latency", cyc, sb_q[0].acc);
                    chk("s_on_illegal", 32'(sb_q[0].illegal), 0);
                    chk("s_twice", 32'(sb_q[0].issued), 0);
                    sb_q[0].issued = 1'b1;
                end
            end
            if (done) begin
                if (sb_q.size() == 0) fail("done_unexpected");
                else begin
                    it = sb_q.pop_front();
                    chk("done_issued", 32'(it.issued), 1);
                    chk("done_latency", cyc, ctl_rise_cyc + 1);
                    model_ret = (model_ret + 1) % (1 << CNT_W);
                end
            end
            if (err) begin
                if (sb_q.size() == 0) fail("err_unexpected");
                else begin
                    it = sb_q.pop_front();
                    chk("err_on_legal", 32'(it.illegal), 1);
                    chk("err_issued", 32'(it.issued), 0);
                    chk("err_latency", cyc, it.acc);
                end
            end
            chk("retired", 32'(retired), model_ret);
            chk("opcode", 32'(opcode), int'(m_ir) / 8192);
            chk("op", 32'(op), (int'(m_ir) / 2048) % 4);
            chk("shift", 32'(shift), (int'(m_ir) / 8) % 4);
            chk("sximm5", 32'(sximm5), 32'(sext(m_ir, 5)));
            chk("sximm8", 32'(sximm8), 32'(sext(m_ir, 8)));
            chk("readnum", 32'(readnum), 32'(exp_reg(m_ir, nsel)));
            chk("writenum", 32'(writenum), 32'(exp_reg(m_ir, nsel)));
        end
    end

    // ---- driver ----
    task automatic send(input logic [15:0] ins);
        int g;
        g = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        while (!bus.in_ready && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!bus.in_ready) begin
            fail("accept_timeout");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        m_ir = ins;
        #1;
        sb_q.push_back('{ins, TRAP && !legal(ins), cyc, 1'b0});
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        do begin
            @(posedge clk);
            #1;
            g++;
        end while (!(sb_q.size() == 0 && bus.in_ready) && g < 400);
        if (g >= 400) fail("idle_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  sweep_sel[4] = '{3'b001, 3'b010, 3'b100, 3'b000};
        logic [2:0]  sweep_exp[4] = '{3'd0, 3'd7, 3'd2, 3'd0};
        int          ret_before;
        int          g;
        bus.in_valid = 1'b0;
        bus.in_instr = 16'h0000;

        // reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_s", 32'(s), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_ir", 32'(sximm8), 0);
        @(negedge clk);
        #2 reset = 1'b1;

        // MOV R1,#5 accepted on the first edge after reset release
        ctl_drop = 0;
        ctl_busy = 3;
        nsel = 3'b001;
        send(16'hD105);
        chk("mov_sximm8", 32'(sximm8), 32'h0005);
        chk("mov_readnum", 32'(readnum), 1);
        wait_idle();
        chk("mov_retired", 32'(retired), 1);

        // ADD R7,R0,R2 with an nsel sweep
        send(16'hA0E2);
        for (int i = 0; i < 4; i++) begin
            nsel = sweep_sel[i];
            #1;
            chk("add_readnum", 32'(readnum), 32'(sweep_exp[i]));
        end
        chk("add_sximm5", 32'(sximm5), 32'h0002);
        wait_idle();

        // in_valid held during busy: IR must not move
        nsel_auto = 1'b1;
        send(16'hD1FF);
        bus.in_valid = 1'b1;
        bus.in_instr = 16'hA0E2;
        g = 0;
        do begin
            @(negedge clk);
            chk("hold_sximm8", 32'(sximm8), 32'hFFFF);
            g++;
        end while (!bus.in_ready && g < 50);
        if (!bus.in_ready) fail("hold_timeout");
        send(16'hA0E2);
        wait_idle();

        // opcode 111
        ret_before = model_ret;
        send(16'hE000);
        wait_idle();
        chk("e000_retired", 32'(retired), TRAP ? ret_before : ret_before + 1);

        // reset pulse in WAIT_DONE
        ctl_busy = 6;
        send(16'hD105);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!s && g < 20);
        if (!s) fail("s_timeout");
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        sb_q.delete();
        model_ret = 0;
        m_ir = 16'h0000;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 1);
        chk("midrst_retired", 32'(retired), 0);
        chk("midrst_done", 32'(done), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_retired_after", 32'(retired), 0);

        // 256 back-to-back completions wrap the counter
        ctl_drop = 0;
        ctl_busy = 1;
        for (int i = 0; i < 256; i++) send(rand_instr(1'b1));
        wait_idle();
        chk("wrap_retired", 32'(retired), 0);

        // randomized traffic
        ctl_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(rand_instr($urandom_range(0, 5) != 0));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        repeat (3) @(posedge clk);
        chk("final_queue", sb_q.size(), 0);
        chk("final_retired", 32'(retired), model_ret);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
